// File: rtl/cpu7_trap_ctrl.sv
// ---------------------------------------------------------------------------
// cpu7_trap_ctrl
//
// Trap and interrupt controller for the cpu7 core, sitting beside fetch.
// It picks one event per IDLE cycle from synchronous exceptions, level
// interrupts and mret. It drains the pipeline through drain_req/drain_ack,
// with a bounded wait. It then issues a one-cycle PC redirect, together with
// the matching mepc/mcause/mstatus update strobes for the CSR file.
//
// Ports
//   clk, reset              core clock, asynchronous active-high reset
//   excp_pc                 PC of the instruction in decode
//   excp_illinstr/ecall/ebreak, mret_req   decode-stage events
//   irq, csr_irq_en         interrupt lines and their per-line enables
//   csr_mstatus_mie         global interrupt enable
//   csr_mtvec, csr_mepc     trap vector / mret return address
//   drain_ack               pipeline is empty
//   drain_req               stall fetch and drain (registered)
//   nop_fetch               squash fetched instruction (combinational)
//   flush_pc_ena, flush_pc  redirect strobe and target (target is comb)
//   mepc_*, mcause_*        CSR write strobes and data (registered)
//   mstatus_trap/mret       mstatus update pulses (registered)
//   drain_tmo_err           sticky: a drain timed out
// ---------------------------------------------------------------------------
module cpu7_trap_ctrl #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NIRQ      = 4,
    parameter int unsigned DRAIN_TMO = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] excp_pc,
    input  logic            excp_illinstr,
    input  logic            excp_ecall,
    input  logic            excp_ebreak,
    input  logic            mret_req,
    input  logic [NIRQ-1:0] irq,
    input  logic [NIRQ-1:0] csr_irq_en,
    input  logic            csr_mstatus_mie,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    input  logic            drain_ack,
    output logic            drain_req,
    output logic            nop_fetch,
    output logic            flush_pc_ena,
    output logic [XLEN-1:0] flush_pc,
    output logic            mepc_we,
    output logic [XLEN-1:0] mepc_wdata,
    output logic            mcause_we,
    output logic [XLEN-1:0] mcause_wdata,
    output logic            mstatus_trap,
    output logic            mstatus_mret,
    output logic            drain_tmo_err
);

    typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;
    typedef enum logic [1:0] {KIND_EXC, KIND_INT, KIND_MRET} kind_t;

    localparam logic [4:0] CAUSE_ILL    = 5'd2;
    localparam logic [4:0] CAUSE_ECALL  = 5'd11;
    localparam logic [4:0] CAUSE_EBREAK = 5'd3;

    // Line 0 is the external interrupt, line 1 the timer, the rest are
    // platform lines mapped from cause 18 upwards.
    function automatic logic [4:0] irq_cause(input int idx);
        if (idx == 0)      return 5'd11;
        else if (idx == 1) return 5'd7;
        else               return 5'(16 + idx);
    endfunction

    state_t          state;
    kind_t           lat_kind;
    logic [4:0]      lat_code;
    logic [XLEN-1:0] lat_pc;
    logic [7:0]      cnt;

    logic [NIRQ-1:0] irq_act;
    logic            int_pend;
    logic [4:0]      int_code;
    logic            any_excp;
    logic            evt_valid;
    kind_t           evt_kind;
    logic [4:0]      evt_code;
    logic [XLEN-1:0] vec_base;

    assign irq_act  = irq & csr_irq_en;
    assign int_pend = csr_mstatus_mie & (|irq_act);
    assign any_excp = excp_illinstr | excp_ecall | excp_ebreak;

    // Scan from the top down so the lowest active index is written last.
    // NOTE: every always_comb output gets a default before any condition,
    // otherwise a missed branch infers a latch.
    always_comb begin
        int_code = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (irq_act[i]) int_code = irq_cause(i);
        end
    end

    always_comb begin
        evt_valid = 1'b1;
        evt_kind  = KIND_EXC;
        evt_code  = '0;
        if (excp_illinstr)      evt_code = CAUSE_ILL;
        else if (excp_ecall)    evt_code = CAUSE_ECALL;
        else if (excp_ebreak)   evt_code = CAUSE_EBREAK;
        else if (int_pend) begin
            evt_kind = KIND_INT;
            evt_code = int_code;
        end
        else if (mret_req)      evt_kind = KIND_MRET;
        else                    evt_valid = 1'b0;
    end

    // Squash the fetched instruction in the cycle an interrupt is accepted,
    // so the interrupted instruction is not partially executed.
    assign nop_fetch = (state == IDLE) & ~any_excp & int_pend;

    // The redirect target is computed combinationally so that mret uses
    // csr_mepc as it stands in the redirect cycle.
    assign vec_base = {csr_mtvec[XLEN-1:2], 2'b00};

    always_comb begin
        flush_pc = '0;
        if (state == REDIRECT) begin
            if (lat_kind == KIND_MRET)
                flush_pc = csr_mepc;
            else if (csr_mtvec[1:0] == 2'b01 && lat_kind == KIND_INT)
                flush_pc = vec_base + (XLEN'(lat_code) << 2);
            else
                flush_pc = vec_base;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lat_kind      <= KIND_EXC;
            lat_code      <= '0;
            lat_pc        <= '0;
            cnt           <= '0;
            drain_req     <= 1'b0;
            flush_pc_ena  <= 1'b0;
            mepc_we       <= 1'b0;
            mepc_wdata    <= '0;
            mcause_we     <= 1'b0;
            mcause_wdata  <= '0;
            mstatus_trap  <= 1'b0;
            mstatus_mret  <= 1'b0;
            drain_tmo_err <= 1'b0;
        end else begin
            flush_pc_ena <= 1'b0;
            mepc_we      <= 1'b0;
            mcause_we    <= 1'b0;
            mstatus_trap <= 1'b0;
            mstatus_mret <= 1'b0;
            case (state)
                IDLE: begin
                    if (evt_valid) begin
                        lat_kind  <= evt_kind;
                        lat_code  <= evt_code;
                        lat_pc    <= excp_pc;
                        cnt       <= '0;
                        drain_req <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 8'd1;
                    // An ack arriving on the timeout cycle still counts as a
                    // clean drain.
                    if (drain_ack || cnt == 8'(DRAIN_TMO)) begin
                        if (!drain_ack) drain_tmo_err <= 1'b1;
                        drain_req    <= 1'b0;
                        flush_pc_ena <= 1'b1;
                        mepc_we      <= (lat_kind != KIND_MRET);
                        mepc_wdata   <= lat_pc;
                        mcause_we    <= (lat_kind != KIND_MRET);
                        mcause_wdata <= {lat_kind == KIND_INT,
                                         {(XLEN - 6){1'b0}}, lat_code};
                        mstatus_trap <= (lat_kind != KIND_MRET);
                        mstatus_mret <= (lat_kind == KIND_MRET);
                        state        <= REDIRECT;
                    end
                end
                REDIRECT: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu7_trap_ctrl.md
Name: cpu7_trap_ctrl

Overview:
- Parametrised successor to the cpu6 exception/interrupt path. Arbitrates synchronous exceptions, NIRQ level-sensitive interrupt lines and mret.
- Drains the pipeline through a request/ack handshake, then issues a one-cycle PC redirect together with mepc/mcause/mstatus updates.
- Sits beside the fetch stage of the cpu7 core, feeding the pcnext mux and the CSR file. Supports direct and vectored mtvec modes and a bounded drain timeout.

Parameters:
- XLEN, 32, datapath/PC width.
- NIRQ, 4, number of interrupt lines (2..16).
- DRAIN_TMO, 15, max cycles waiting for drain_ack before forcing redirect (1..255).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- excp_pc  in  XLEN  PC of the instruction currently in decode.
- excp_illinstr  in  1  illegal instruction in decode.
- excp_ecall  in  1  ecall in decode.
- excp_ebreak  in  1  ebreak in decode.
- mret_req  in  1  mret in decode.
- irq  in  NIRQ  interrupt lines (registered, level).
- csr_irq_en  in  NIRQ  per-line enable (mie bits).
- csr_mstatus_mie  in  1  global interrupt enable.
- csr_mtvec  in  XLEN  trap vector; [1:0]=01 vectored, else direct.
- csr_mepc  in  XLEN  return address for mret.
- drain_ack  in  1  pipeline reports empty.
- drain_req  out  1  stall fetch and drain pipeline.
- nop_fetch  out  1  replace fetched instruction with NOP.
- flush_pc_ena  out  1  redirect strobe.
- flush_pc  out  XLEN  redirect target.
- mepc_we  out  1  write mepc.
- mepc_wdata  out  XLEN  value for mepc.
- mcause_we  out  1  write mcause.
- mcause_wdata  out  XLEN  value for mcause.
- mstatus_trap  out  1  pulse: MPIE<=MIE, MIE<=0.
- mstatus_mret  out  1  pulse: MIE<=MPIE, MPIE<=1.
- drain_tmo_err  out  1  sticky: a drain timed out.

Behaviour:
- Reset (async): state IDLE; all outputs 0; internal pc/cause/kind registers and counter 0. Reset mid-DRAIN or mid-REDIRECT aborts with no CSR writes.
- Pending interrupt: int_pend = csr_mstatus_mie & |(irq & csr_irq_en).
- Interrupt priority: lowest enabled index wins.
- Interrupt cause: irq[0]=11 (ext), irq[1]=7 (timer), irq[i>=2]=16+i. mcause bit XLEN-1 = 1.
- Event priority in IDLE: illinstr (cause 2) > ecall (11) > ebreak (3) > interrupt > mret.
- IDLE: on any event, latch kind, cause and excp_pc; go to DRAIN; set counter 0.
  - nop_fetch is combinational and asserted in IDLE whenever an interrupt is the winning event.
- DRAIN: drain_req=1; counter increments each cycle.
  - drain_ack=1 -> REDIRECT.
  - counter==DRAIN_TMO without ack -> REDIRECT, and set drain_tmo_err.
  - New events are ignored here. Interrupts stay pending because they are level. Exceptions are held by the stalled decode.
- REDIRECT: exactly one cycle; drain_req=0; flush_pc_ena=1; then IDLE.
  - Trap case: mepc_we=1 with latched pc; mcause_we=1 with latched cause; mstatus_trap=1.
  - Trap target: vectored and interrupt -> {mtvec[XLEN-1:2],2'b00} + 4*cause_code (XLEN wrap-around, no saturation); otherwise {mtvec[XLEN-1:2],2'b00}.
  - mret case: flush_pc=csr_mepc sampled this cycle; mstatus_mret=1; no mepc/mcause write.
- Latency: event at cycle 0, ack at cycle k -> flush_pc_ena at cycle k+1. Minimum is 2 cycles (ack already high in cycle 1).
- drain_tmo_err clears only on reset.
- All outputs are registered except nop_fetch and flush_pc. flush_pc is valid only with flush_pc_ena.

Test Plan:
- excp_illinstr=1, excp_pc=0x100, mtvec=0x200, ack two cycles later -> drain_req for 2 cycles, then one-cycle flush_pc_ena with flush_pc=0x200, mepc=0x100, mcause=2, mstatus_trap=1.
- irq=4'b0011, all enabled, mie=1, mtvec=0x201 (vectored) -> cause 11 chosen, mcause=0x8000000B, flush_pc=0x22C, nop_fetch=1 on the accept cycle.
- irq[1]=1 with csr_mstatus_mie=0 for 10 cycles -> no drain_req; set mie=1 -> trap taken, mcause=0x80000007.
- mret_req=1 and excp_ecall=1 in the same cycle -> ecall wins, mcause=11; mret in a later IDLE cycle with csr_mepc=0x440 -> flush_pc=0x440, mstatus_mret=1, mepc_we=0.
- drain_ack held 0, DRAIN_TMO=15 -> redirect occurs 16 cycles after entering DRAIN, drain_tmo_err=1 and stays 1 until reset.
- Assert reset during DRAIN -> all outputs 0 immediately, state IDLE; after release the same held exception is re-taken cleanly.
